// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier with architectural HI/LO result registers.
// Signed operands are multiplied as magnitudes and the product sign is applied once at the end.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Handshake: start_mult is a single-cycle request honoured only while busy is low;
   // done pulses for one cycle with hi/lo already holding the new product.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               neg;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     step_sum;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] product;

   always_comb begin
      a_mag = (mult_sign && srca[WIDTH-1]) ? (~srca + {{(WIDTH-1){1'b0}}, 1'b1}) : srca;
      b_mag = (mult_sign && srcb[WIDTH-1]) ? (~srcb + {{(WIDTH-1){1'b0}}, 1'b1}) : srcb;
   end

   // Upper half accumulates the partial product; lower half holds the not-yet-consumed multiplier bits.
   always_comb begin
      step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
      acc_step = {step_sum, acc[WIDTH-1:1]};
      product  = neg ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_mult) state_next = RUN;
         RUN:     if (cnt == CNT_ONE) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand <= '0;
         acc   <= '0;
         cnt   <= '0;
         neg   <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= (state == FINISH);
         case (state)
            IDLE: begin
               if (start_mult) begin
                  mcand <= a_mag;
                  acc   <= {{WIDTH{1'b0}}, b_mag};
                  cnt   <= CNT_LOAD;
                  neg   <= mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
               end
            end
            RUN: begin
               acc <= acc_step;
               cnt <= cnt - CNT_ONE;
            end
            FINISH: begin
               hi <= product[2*WIDTH-1:WIDTH];
               lo <= product[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// Directed and randomized checks of mult_unit against an arithmetic product model.
module tb_mult_unit;

   logic        clk;
   logic        reset;
   logic        start_mult;
   logic        mult_sign;
   logic [31:0] srca, srcb;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_hi = '0, exp_lo = '0;
   logic [31:0] pend_hi, pend_lo;

   mult_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .mult_sign  (mult_sign),
      .srca       (srca),
      .srcb       (srcb),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      return 64'(sa * sb);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      start_mult = 1'b1;
      srca       = a;
      srcb       = b;
      mult_sign  = s;
      {pend_hi, pend_lo} = ref_mul(a, b, s);
   endtask

   // Follows an issued op to its done cycle; optionally pokes a second start while busy.
   task automatic track(input int poke);
      @(negedge clk);
      for (int k = 1; k <= 33; k++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("hi_hold", hi, exp_hi);
         chk("lo_hold", lo, exp_lo);
         start_mult = (k == poke);
         if (k == poke) begin
            srca = 32'd3;
            srcb = 32'd3;
         end else begin
            srca = $urandom;
            srcb = $urandom;
         end
         mult_sign = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("hi_result", hi, pend_hi);
      chk("lo_result", lo, pend_lo);
      exp_hi = pend_hi;
      exp_lo = pend_lo;
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s);
      issue(a, b, s);
      track(0);
      @(negedge clk);
      chk("done_single", done, 0);
      chk("hi_keep", hi, exp_hi);
   endtask

   initial begin
      logic [31:0] corners [6];
      logic [31:0] ra, rb;
      corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

      reset = 1'b1; start_mult = 1'b0; mult_sign = 1'b0; srca = '0; srcb = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Full-range unsigned, sign handling and signed corners
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("t1_hi", exp_hi, 64'hFFFF_FFFE);
      op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      chk("t2s_hi", exp_hi, 64'hFFFF_FFFF);
      op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      chk("t2u_hi", exp_hi, 64'h0000_0001);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      op(32'h8000_0000, 32'h8000_0000, 1'b1);
      chk("t3a_hi", exp_hi, 64'h4000_0000);
      op(32'h8000_0000, 32'h0000_0001, 1'b1);
      op(32'h0000_0000, 32'h8000_0000, 1'b1);

      // Start while busy is ignored, operands changed after capture
      issue(32'd7, 32'd6, 1'b0);
      track(5);
      chk("t4_lo42", lo, 64'd42);
      @(negedge clk);
      chk("t4_single", done, 0);
      chk("t4_idle", busy, 0);

      // Asynchronous reset mid-operation
      issue(32'h1234_5678, 32'h9ABC_DEF0, 1'($urandom_range(0, 1)));
      @(negedge clk);
      start_mult = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_hi", hi, 0);
      chk("t5_lo", lo, 0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("t5_no_done", done, 0);
         chk("t5_no_busy", busy, 0);
         chk("t5_hi_zero", hi, 0);
      end
      op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

      // Back-to-back: second start in the done cycle of the first
      issue(32'd5, 32'd5, 1'b0);
      track(0);
      chk("t6_lo25", lo, 64'd25);
      issue(32'd3, 32'd4, 1'b0);
      track(0);
      chk("t6_lo12", lo, 64'd12);
      @(negedge clk);
      chk("t6_single", done, 0);

      // Randomized operands, biased towards corners
      for (int n = 0; n < 16; n++) begin
         case ($urandom_range(0, 2))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin
               ra = corners[$urandom_range(0, 5)];
               rb = corners[$urandom_range(0, 5)];
            end
            default: begin ra = 32'($urandom_range(0, 255)); rb = $urandom; end
         endcase
         op(ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative multiply unit: the execution-side responder to the controller's start_mult/mult_sign command.
- Computes the full 64-bit product of two 32-bit operands, signed or unsigned, one radix-2 step per cycle.
- Holds the result in architectural HI/LO registers, which MFHI/MFLO read through the execute-stage output select.
- Exports busy so hazard logic can stall MULT/MULTU/MFHI/MFLO while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; product and HI:LO are 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start_mult  input  1  request pulse from execute stage; sampled only in IDLE
- mult_sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start_mult
- srca  input  WIDTH  multiplicand (rs), sampled with start_mult
- srcb  input  WIDTH  multiplier (rt), sampled with start_mult
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse; HI/LO hold the new product in that cycle
- hi  output  WIDTH  upper half of last completed product
- lo  output  WIDTH  lower half of last completed product

Behaviour:
Reset (asynchronous, any state):
- state=IDLE; busy=0; done=0; hi=0; lo=0; iteration counter=0.
- Reset mid-operation aborts the multiply. No partial result is ever written.

States:
- IDLE: busy=0. start_mult=1 at an edge -> capture operands, go to RUN.
  - Signed (mult_sign=1): capture magnitudes |srca| and |srcb| as WIDTH-bit unsigned values (0x80000000 magnitude = 0x80000000). neg = srca[MSB] ^ srcb[MSB].
  - Unsigned: capture raw values; neg = 0.
  - Clear accumulator, load counter = WIDTH.
- RUN: busy=1. Each cycle, one shift-add step on the 2*WIDTH-bit accumulator; counter decrements. Last step (counter 1->0) -> go to FINISH.
- FINISH: busy=1. At the edge leaving FINISH:
  - {hi,lo} <= neg ? two's-complement negation of accumulator : accumulator.
  - done=1 in the following cycle; state -> IDLE.
- done is a registered pulse, exactly one cycle. busy=0 in that cycle.

Latency:
- start_mult sampled at edge E0.
- busy=1 for cycles after E0 up to edge E0+WIDTH+1 (WIDTH+1 cycles).
- hi/lo updated and done=1 after edge E0+WIDTH+1 (33 cycles for WIDTH=32).

Boundary conditions:
- hi/lo keep the previous product for the whole operation. Stalling dependent MFHI/MFLO on busy is the pipeline's job.
- start_mult while busy=1 is ignored; no queueing.
- Operand or mult_sign changes after capture have no effect.
- start_mult in the done cycle (state IDLE) is accepted. The new op starts; the done pulse and new hi/lo of the previous op are unaffected.
- Zero operand: normal full-latency operation; result 0, neg forced to give 0 (negation of 0 is 0).
- No overflow is possible; full 2*WIDTH-bit product is always exact.

Test Plan:
1. Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after start; busy high 33 cycles; hi/lo unchanged before done.
2. Operands 0xFFFFFFFF x 0x00000002:
   - signed -> hi=0xFFFFFFFF, lo=0xFFFFFFFE
   - unsigned -> hi=0x00000001, lo=0xFFFFFFFE
   - signed 0xFFFFFFFF x 0xFFFFFFFF -> hi=0, lo=1
3. Signed corner cases:
   - 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0
   - 0x80000000 x 0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000
   - 0 x 0x80000000 -> hi=lo=0
4. Start 7x6 unsigned; at cycle 5 pulse start_mult with 3x3 and change srca -> result hi=0, lo=42. Second request ignored; single done pulse.
5. Start 0x12345678 x 0x9ABCDEF0; assert reset at cycle 10 -> busy=0, done=0, hi=lo=0 immediately. No done pulse afterwards. A fresh start after reset produces the correct product.
6. Issue 5x5, then 3x4 in the done cycle of the first -> first done with lo=25; second done 33 cycles later with lo=12, hi=0.
